uart_tx_buffered: RTL and testbench

Byte FIFO plus 8N1 UART serializer directly downstream of the data framer. It accepts framed bytes (start marker, payload, end marker) through a write-enable/full handshake, buffers them, and shifts them onto the board's UART TX pin. It drives the full back-pressure the framer stalls on, so it must never lose an accepted byte.

---
 rtl/uart_tx_buffered.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Byte FIFO feeding an 8N1 UART transmitter: bytes from the framer are buffered and
// shifted out LSB first on a registered, idle-high tx line.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wr_data_i,
    input  logic                     wr_en_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic                     busy_o,
    output logic                     tx_o,
    output logic [1:0]               state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic push;
    logic pop;
    logic baud_end;

    // Handshake: a byte transfers on every rising edge where wr_en_i=1 and full_o=0.
    // full_o comes only from the registered count, so upstream may build wr_en_i from it.
    assign full_o   = (count == LW'(DEPTH));
    assign empty_o  = (count == '0);
    assign level_o  = count;
    assign state_o  = state;

    assign push     = wr_en_i && !full_o;
    assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));
    assign pop      = !empty_o &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            // A refused write is sticky evidence that the framer ignored back-pressure.
            if (wr_en_i && full_o) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // tx_o and busy_o are loaded with the value of the state being entered,
    // so the line changes exactly on the edge the state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        baud   <= '0;
                        state  <= ST_START;
                        tx_o   <= 1'b0;
                        busy_o <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        tx_o    <= shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud  <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (pop) begin
                            // Back-to-back frame: no idle gap after the stop bit.
                            shift <= mem[rd_ptr];
                            state <= ST_START;
                            tx_o  <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            tx_o   <= 1'b1;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered at CLKS_PER_BIT=4, DEPTH=4: table of single-byte frames
// plus directed back-to-back, overflow, full-refill and mid-frame reset sequences.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk;
    logic          rst;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          busy;
    logic          tx;
    logic [1:0]    state;

    int n_tests;
    int n_fail;
    int cyc;

    logic [7:0] exp_q[$];
    int         start_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line level per bit period: [0]=start ... [9]=stop
    } vec_t;
    vec_t vecs[6];

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data_i  (wr_data),
        .wr_en_i    (wr_en),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (level),
        .overflow_o (overflow),
        .busy_o     (busy),
        .tx_o       (tx),
        .state_o    (state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_data = b;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (empty && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    // ---------------- receiver + scoreboard ----------------
    // Samples tx at negedges; first low sample is frame cycle 1, bit b sampled at cycle 3+4b.
    initial begin
        int         rx_cnt;
        int         b;
        logic [7:0] rx_sh;
        rx_cnt = 0;
        rx_sh  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_cnt = 0;
            end else if (rx_cnt == 0) begin
                if (tx == 1'b0) begin
                    rx_cnt = 1;
                    start_q.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= 3 && ((rx_cnt - 3) % CPB) == 0) begin
                    b = (rx_cnt - 3) / CPB;
                    if (b == 0) begin
                        check("rx_start_bit", 32'(tx), 32'd0);
                    end else if (b <= 8) begin
                        rx_sh[b-1] = tx;
                    end else begin
                        check("rx_stop_bit", 32'(tx), 32'd1);
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL rx_unexpected_frame: got %0h expected no frame", rx_sh);
                        end else begin
                            check("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
                        end
                    end
                end
                if (rx_cnt == 10 * CPB) begin
                    rx_cnt = 0;
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [LW-1:0] max_level;
        logic          prev_full;
        logic          accepted;
        logic          saw_low;
        int            byte_idx;
        int            refills;

        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        vecs[0] = '{data: 8'hA5, line: 10'h34A};
        vecs[1] = '{data: 8'h00, line: 10'h200};
        vecs[2] = '{data: 8'hFF, line: 10'h3FE};
        vecs[3] = '{data: 8'h01, line: 10'h202};
        vecs[4] = '{data: 8'h80, line: 10'h300};
        vecs[5] = '{data: 8'h3C, line: 10'h278};

        // Reset and idle: {tx,empty,full,busy,overflow,level,state} = 1,1,0,0,0,0,0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", 32'({tx, empty, full, busy, overflow, level, state}), 32'h300);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_after_reset", 32'({tx, empty, full, busy, overflow, level, state}), 32'h300);
        end

        // Single-byte frames from the table
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].data);
            write_byte(vecs[i].data);
            @(negedge clk);
            check("accept_level", 32'({empty, level, busy, tx}), 32'({1'b0, 3'd1, 1'b0, 1'b1}));
            for (int c = 1; c <= 10 * CPB; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    check("pop_level", 32'({empty, level}), 32'({1'b1, 3'd0}));
                end
                check("frame_line", 32'({busy, tx}), 32'({1'b1, vecs[i].line[(c-1)/CPB]}));
            end
            @(negedge clk);
            check("frame_end", 32'({busy, tx, empty}), 32'b011);
        end

        // Back-to-back: three consecutive writes, contiguous frames
        start_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'hBB);
        max_level = '0;
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'hAA;
        @(negedge clk);
        wr_data = 8'h12;
        if (level > max_level) max_level = level;
        @(negedge clk);
        wr_data = 8'hBB;
        if (level > max_level) max_level = level;
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 125; i++) begin
            if (level > max_level) max_level = level;
            @(negedge clk);
        end
        check("b2b_level_peak", 32'(max_level), 32'd2);
        check("b2b_drained", 32'({level, busy, tx}), 32'({3'd0, 1'b0, 1'b1}));
        check("b2b_frame_count", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            check("b2b_gap_1", 32'(start_q[1] - start_q[0]), 32'd40);
            check("b2b_gap_2", 32'(start_q[2] - start_q[1]), 32'd40);
        end

        // Full / overflow: 0x01..0x06 back-to-back, 0x06 dropped
        for (int d = 1; d <= 5; d++) exp_q.push_back(8'(d));
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h01;
        for (int d = 2; d <= 6; d++) begin
            @(negedge clk);
            if (d == 6) begin
                check("fill_full_pre", 32'({full, level, overflow}), 32'({1'b1, 3'd4, 1'b0}));
            end
            wr_data = 8'(d);
        end
        @(negedge clk);
        check("fill_overflow", 32'({full, level, overflow}), 32'({1'b1, 3'd4, 1'b1}));
        wr_en = 1'b0;
        wait_idle(400);
        check("overflow_sticky", 32'({overflow, level}), 32'({1'b1, 3'd0}));

        // Full with wr_en held high: write refused on the pop cycle, accepted after
        @(negedge clk);
        wr_data   = 8'h40;
        wr_en     = 1'b1;
        byte_idx  = 0;
        refills   = 0;
        prev_full = 1'b0;
        for (int t = 0; t < 800 && byte_idx < 12; t++) begin
            if (prev_full && !full) begin
                refills++;
                check("refill_level", 32'(level), 32'd3);
            end
            accepted  = !full;
            prev_full = full;
            @(posedge clk);
            #1;
            if (accepted) begin
                exp_q.push_back(wr_data);
                byte_idx++;
                wr_data = wr_data + 8'd1;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("refill_all_sent", 32'(byte_idx), 32'd12);
        check("refill_seen", 32'(refills > 0), 32'd1);
        wait_idle(600);

        // Reset mid-frame with two bytes queued
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h11;
        @(negedge clk);
        wr_data = 8'h22;
        @(negedge clk);
        wr_data = 8'h33;
        @(negedge clk);
        wr_en = 1'b0;
        check("abort_queued", 32'(level), 32'd2);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_reset", 32'({tx, empty, full, busy, overflow, level, state}), 32'h300);
        rst = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!tx || busy) saw_low = 1'b1;
        end
        check("abort_no_frames", 32'(saw_low), 32'd0);
        exp_q.push_back(8'h5A);
        write_byte(8'h5A);
        wait_idle(100);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
